wb_port_scheduler: RTL and testbench
====================================

// Module: wb_port_scheduler
// PURPOSE
//  Write-back scheduler for the single-write-port register file of the SEQ core. Takes one retiring
//  instruction (icode, rA, rB, cnd, valE, valM) per handshake and derives dstE/dstM. Issues up to two
//  register writes, one per cycle, E first then M. Tracks halt and invalid-icode status for the core.
// PARAMETERS
//  DATA_W  64     register/value width
//  CNT_W   16     width of issued-write counter
// PORTS
//  clk         in   1       core clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  in_valid    in   1       retiring instruction presented
//  in_ready    out  1       scheduler can accept this cycle
//  icode       in   4       instruction code
//  rA, rB      in   4 each  register specifiers
//  cnd         in   1       condition result (cmovXX)
//  valE, valM  in   DATA_W  ALU result / memory read value
//  wr_en       out  1       register-file write strobe
//  wr_addr     out  4       write register ID (RNONE=4'hF when idle)
//  wr_data     out  DATA_W  write data
//  instr_done  out  1       final cycle of current instruction's write-back
//  halted      out  1       sticky: halt retired
//  err         out  1       sticky: icode > 4'hB retired
//  wb_count    out  CNT_W   number of writes issued, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, wr_en=0, wr_addr=4'hF, wr_data=0, instr_done=0, halted=0,
//    err=0, wb_count=0, in_ready=1. Reset mid-write abandons latched writes; wr_en drops with rst.
//  - Accept when in_valid & in_ready at a rising edge; inputs latched, dst decoded at accept.
//  - dstE: icode 2 -> rB if cnd else F; 3,6 -> rB; 8,9,A,B -> RSP(4); else F.
//    dstM: icode 5,B -> rA; else F.
//  - FSM states IDLE, WR_E, WR_M, NOP. From accept: WR_E if dstE!=F; else WR_M if dstM!=F; else NOP.
//    WR_E -> WR_M if dstM!=F, else IDLE. WR_M -> IDLE. NOP -> IDLE.
//  - Outputs are Moore decodes of state + latched regs. WR_E drives wr_en=1, wr_addr=dstE, wr_data=valE.
//    WR_M drives wr_en=1, wr_addr=dstM, wr_data=valM. NOP drives wr_en=0.
//  - instr_done=1 in the last non-IDLE state of an instruction (WR_M, NOP, or WR_E without M).
//  - Latency: first write visible the cycle after accept. 1 write = 1 cycle, 2 writes = 2 cycles.
//  - in_ready = ~halted & (IDLE | instr_done). A back-to-back accept during the final cycle goes
//    straight to the next instruction's first state; no IDLE bubble.
//  - dstE==dstM (popq %rsp): both writes issued, E then M; M value is final.
//  - icode 0 (halt): NOP cycle, then halted=1; in_ready held 0 until rst.
//  - icode >= 4'hC: NOP cycle, no writes, err=1 sticky until rst; acceptance continues.
//  - wb_count increments by 1 on every cycle with wr_en=1; wraps all-ones -> 0 without flag.
//  - in_valid while in_ready=0: ignored, not latched; upstream must hold.
// STRUCTURE
//  - y86_pkg: icode constants (IHALT..IPOPQ), RNONE=4'hF, RRSP=4'h4, FSM state enum.
//  - Sub-module wb_dst_decode: combinational (icode, rA, rB, cnd) -> (dstE, dstM), reused by decode/hazard logic.
//  - Top: FSM, latch regs, output decode, status flags, counter.
// TESTING
//  1 Reset: assert rst mid-sim -> wr_en=0, wr_addr=F, in_ready=1, halted=0, err=0, wb_count=0 at once.
//  2 OPq: icode=6, rB=5, valE=114 -> next cycle wr_en=1, wr_addr=5, wr_data=114, instr_done=1; wb_count=1.
//  3 popq: icode=B, rA=3, valE=0x100, valM=912 -> cycle1 addr4/0x100, cycle2 addr3/912 + instr_done;
//    mrmovq (icode=5, rA=9, valM=120) accepted in cycle2 -> cycle3 addr9/120, no bubble.
//  4 popq %rsp: icode=B, rA=4, valE=8, valM=72 -> addr4/8 then addr4/72; model reg4 = 72.
//  5 cmov not taken: icode=2, cnd=0 -> one NOP cycle, instr_done=1, wr_en=0. icode=14 -> err=1, stays
//    after next valid OPq. icode=0 -> halted=1, in_ready=0 thereafter, in_valid ignored.
//  6 Wrap/reset: preload via 2^CNT_W writes -> wb_count returns to 0. rst during WR_M -> wr_en falls
//    asynchronously, pending write never issued.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 write-back definitions:
// icodes, register IDs and scheduler states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_E,
    S_WR_M,
    S_NOP
  } wb_state_t;

endpackage

// File: rtl/wb_dst_decode.sv
// Destination register decode for E and M
// write-back ports of a retiring instruction.
module wb_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  // dstE: cmov gated by cnd, stack ops target %rsp
  always_comb begin
    dst_e = RNONE;
    unique case (icode)
      IRRMOVQ: dst_e = cnd ? rb : RNONE;
      IIRMOVQ,
      IOPQ:    dst_e = rb;
      ICALL,
      IRET,
      IPUSHQ,
      IPOPQ:   dst_e = RRSP;
      default: dst_e = RNONE;
    endcase
  end

  // dstM: memory loads write rA
  always_comb begin
    dst_m = RNONE;
    unique case (icode)
      IMRMOVQ,
      IPOPQ:   dst_m = ra;
      default: dst_m = RNONE;
    endcase
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Serialises E/M write-backs onto one
// register-file write port; tracks halt/err.
module wb_port_scheduler
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              instr_done,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  wb_count
);

  wb_state_t state, state_n, first_st;

  logic [3:0]        dec_e, dec_m;
  logic [3:0]        dst_e, dst_m;
  logic [DATA_W-1:0] val_e, val_m;
  logic              lat_halt, lat_bad;
  logic              accept, last;

  wb_dst_decode u_dec (
    .icode (icode),
    .ra    (rA),
    .rb    (rB),
    .cnd   (cnd),
    .dst_e (dec_e),
    .dst_m (dec_m)
  );

  assign accept = in_valid & in_ready;

  // halt retiring in its NOP cycle must not
  // let a follower slip in behind it
  assign in_ready = ~halted
    & ((state == S_IDLE)
    | (instr_done
       & ~((state == S_NOP) & lat_halt)));

  // first state of the instruction being accepted
  always_comb begin
    first_st = S_NOP;
    if (dec_e != RNONE)
      first_st = S_WR_E;
    else if (dec_m != RNONE)
      first_st = S_WR_M;
  end

  assign last = (state == S_IDLE) | instr_done;

  // next-state: chain into next instr, no bubble
  always_comb begin
    state_n = state;
    unique case (1'b1)
      last:    state_n = accept ? first_st : S_IDLE;
      default: state_n = S_WR_M;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // latch the instruction at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_e    <= RNONE;
      dst_m    <= RNONE;
      val_e    <= '0;
      val_m    <= '0;
      lat_halt <= 1'b0;
      lat_bad  <= 1'b0;
    end else if (accept) begin
      dst_e    <= dec_e;
      dst_m    <= dec_m;
      val_e    <= valE;
      val_m    <= valM;
      lat_halt <= (icode == IHALT);
      lat_bad  <= (icode > IPOPQ);
    end
  end

  // Moore output decode
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = RNONE;
    wr_data    = '0;
    instr_done = 1'b0;
    unique case (state)
      S_WR_E: begin
        wr_en      = 1'b1;
        wr_addr    = dst_e;
        wr_data    = val_e;
        instr_done = (dst_m == RNONE);
      end
      S_WR_M: begin
        wr_en      = 1'b1;
        wr_addr    = dst_m;
        wr_data    = val_m;
        instr_done = 1'b1;
      end
      S_NOP:   instr_done = 1'b1;
      default: instr_done = 1'b0;
    endcase
  end

  // sticky status set as the NOP cycle retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
      err    <= 1'b0;
    end else if (state == S_NOP) begin
      if (lat_halt) halted <= 1'b1;
      if (lat_bad)  err    <= 1'b1;
    end
  end

  // issued-write counter, free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        wb_count <= '0;
    else if (wr_en) wb_count <= wb_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler
// with a shadow register file.
module tb_wb_port_scheduler;

  localparam int DW = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    icode, rA, rB;
  logic          cnd;
  logic [DW-1:0] valE, valM;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          instr_done;
  logic          halted;
  logic          err;
  logic [CW-1:0] wb_count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] rf [16];

  wb_port_scheduler #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .rA         (rA),
    .rB         (rB),
    .cnd        (cnd),
    .valE       (valE),
    .valM       (valM),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .instr_done (instr_done),
    .halted     (halted),
    .err        (err),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  // shadow register file fed by the write port
  always @(posedge clk)
    if (wr_en) rf[wr_addr] <= wr_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic,
                       input logic [3:0] a,
                       input logic [3:0] b,
                       input logic c,
                       input logic [DW-1:0] e,
                       input logic [DW-1:0] m);
    in_valid = 1'b1;
    icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rst = 1'b1; in_valid = 1'b0;
    icode = 4'h1; rA = 4'hF; rB = 4'hF;
    cnd = 1'b0; valE = '0; valM = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_wr_en",  64'(wr_en), 64'd0);
    chk("rst_addr",   64'(wr_addr), 64'hF);
    chk("rst_data",   wr_data, 64'd0);
    chk("rst_ready",  64'(in_ready), 64'd1);
    chk("rst_done",   64'(instr_done), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err",    64'(err), 64'd0);
    chk("rst_count",  64'(wb_count), 64'd0);

    // OPq single write
    drive(4'h6, 4'hF, 4'h5, 1'b0, 64'd114, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("opq_en",   64'(wr_en), 64'd1);
    chk("opq_addr", 64'(wr_addr), 64'd5);
    chk("opq_data", wr_data, 64'd114);
    chk("opq_done", 64'(instr_done), 64'd1);
    tick();
    chk("opq_idle",  64'(wr_en), 64'd0);
    chk("opq_count", 64'(wb_count), 64'd1);

    // popq then back-to-back mrmovq
    drive(4'hB, 4'h3, 4'hF, 1'b0, 64'h100, 64'd912);
    tick();
    chk("pop_e_addr", 64'(wr_addr), 64'd4);
    chk("pop_e_data", wr_data, 64'h100);
    chk("pop_e_done", 64'(instr_done), 64'd0);
    chk("pop_e_rdy",  64'(in_ready), 64'd0);
    drive(4'h5, 4'h9, 4'hF, 1'b0, 64'd0, 64'd120);
    tick();
    chk("pop_m_addr", 64'(wr_addr), 64'd3);
    chk("pop_m_data", wr_data, 64'd912);
    chk("pop_m_done", 64'(instr_done), 64'd1);
    chk("pop_m_rdy",  64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("mr_en",   64'(wr_en), 64'd1);
    chk("mr_addr", 64'(wr_addr), 64'd9);
    chk("mr_data", wr_data, 64'd120);
    tick();
    chk("mr_count", 64'(wb_count), 64'd4);
    chk("rf3",      rf[3], 64'd912);

    // popq %rsp: M value wins
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd8, 64'd72);
    tick();
    in_valid = 1'b0;
    chk("rsp_e_addr", 64'(wr_addr), 64'd4);
    chk("rsp_e_data", wr_data, 64'd8);
    tick();
    chk("rsp_m_addr", 64'(wr_addr), 64'd4);
    chk("rsp_m_data", wr_data, 64'd72);
    tick();
    chk("rsp_rf4",   rf[4], 64'd72);
    chk("rsp_count", 64'(wb_count), 64'd6);

    // cmov not taken
    drive(4'h2, 4'h1, 4'h7, 1'b0, 64'd5, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("cmov_en",   64'(wr_en), 64'd0);
    chk("cmov_done", 64'(instr_done), 64'd1);
    chk("cmov_addr", 64'(wr_addr), 64'hF);
    tick();

    // invalid icode
    drive(4'hE, 4'h1, 4'h2, 1'b0, 64'd1, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bad_en", 64'(wr_en), 64'd0);
    tick();
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_rdy", 64'(in_ready), 64'd1);
    drive(4'h6, 4'hF, 4'h2, 1'b0, 64'd55, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("bad_op_addr", 64'(wr_addr), 64'd2);
    chk("bad_op_data", wr_data, 64'd55);
    chk("bad_sticky",  64'(err), 64'd1);
    tick();
    chk("bad_count", 64'(wb_count), 64'd7);

    // halt
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    tick();
    chk("halt_nop",  64'(instr_done), 64'd1);
    chk("halt_en",   64'(wr_en), 64'd0);
    chk("halt_rdy0", 64'(in_ready), 64'd0);
    drive(4'h6, 4'hF, 4'h1, 1'b0, 64'd99, 64'd0);
    tick();
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_rdy1", 64'(in_ready), 64'd0);
    tick();
    chk("halt_ign_en", 64'(wr_en), 64'd0);
    chk("halt_ign_ct", 64'(wb_count), 64'd7);
    in_valid = 1'b0;

    // asynchronous reset, checked before any edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst_halted", 64'(halted), 64'd0);
    chk("arst_err",    64'(err), 64'd0);
    chk("arst_count",  64'(wb_count), 64'd0);
    chk("arst_rdy",    64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    tick();

    // counter wrap with back-to-back OPq
    drive(4'h6, 4'hF, 4'h1, 1'b0, 64'd3, 64'd0);
    for (int n = 0; n < 256; n++) tick();
    chk("wrap_pre", 64'(wb_count), 64'd255);
    in_valid = 1'b0;
    tick();
    chk("wrap_zero", 64'(wb_count), 64'd0);
    chk("wrap_idle", 64'(wr_en), 64'd0);

    // reset during WR_M drops the pending write
    drive(4'hB, 4'h3, 4'hF, 1'b0, 64'd1, 64'd2);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_m_en",   64'(wr_en), 64'd1);
    chk("mid_m_addr", 64'(wr_addr), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_en",   64'(wr_en), 64'd0);
    chk("mid_rst_addr", 64'(wr_addr), 64'hF);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("mid_rf3",   rf[3], 64'd912);
    chk("mid_count", 64'(wb_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
